// File: rtl/download_mem_arbiter_pkg.sv
// rtl/download_mem_arbiter_pkg.sv - shared types and default sizing for the download/fetch memory arbiter
package download_mem_arbiter_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_HIGH_WATER = DEFAULT_FIFO_DEPTH - 2;
  localparam int DL_ADDR_WIDTH      = 26;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    WAIT_DATA
  } arb_state_t;

  typedef struct packed {
    logic [DL_ADDR_WIDTH-1:0] addr;
    logic [7:0]               data;
  } dl_entry_t;

endpackage

// File: rtl/download_mem_arbiter_if.sv
// rtl/download_mem_arbiter_if.sv - download, fetch and memory port bundle; master is the arbiter side
interface download_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 26
);
  logic                  dl_wr;
  logic [ADDR_WIDTH-1:0] dl_addr;
  logic [7:0]            dl_data;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [7:0]            rd_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [7:0]            mem_rdata;
  logic                  busy;
  logic                  overflow;
  logic [15:0]           stat_wr_count;
  logic [15:0]           stat_rd_count;

  modport master (
    input  dl_wr, dl_addr, dl_data, rd_req, rd_addr,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rd_ack, rd_valid, rd_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, overflow, stat_wr_count, stat_rd_count
  );

  modport slave (
    output dl_wr, dl_addr, dl_data, rd_req, rd_addr,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rd_ack, rd_valid, rd_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, overflow, stat_wr_count, stat_rd_count
  );
endinterface

// File: rtl/download_mem_arbiter_sync_fifo.sv
// rtl/download_mem_arbiter_sync_fifo.sv - single-clock FIFO; a push is accepted when full only if a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/download_mem_arbiter.sv
// rtl/download_mem_arbiter.sv - arbitrates the 8-bit memory port between buffered download writes and fetch reads
// ARB_STATS_EN: when defined, builds saturating accepted-write/accepted-read counters.
module download_mem_arbiter
  import download_mem_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DL_ADDR_WIDTH,
  parameter int HIGH_WATER = FIFO_DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  download_mem_arbiter_if.master  bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  arb_state_t            state, state_next;
  dl_entry_t             push_entry, head_entry;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [LW-1:0]         fifo_level;
  logic                  load_write, load_read, rd_ack_c;
  logic                  mem_req_q, mem_we_q, rd_valid_q, overflow_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_wdata_q, rd_data_q;

  assign push_entry.addr = DL_ADDR_WIDTH'(bus.dl_addr);
  assign push_entry.data = bus.dl_data;

  sync_fifo #(
    .WIDTH ($bits(dl_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.dl_wr),
    .pop   (fifo_pop),
    .din   (push_entry),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_next = state;
    load_write = 1'b0;
    load_read  = 1'b0;
    fifo_pop   = 1'b0;
    rd_ack_c   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level >= LW'(HIGH_WATER)) begin
          state_next = WRITE;
          load_write = 1'b1;
        end else if (bus.rd_req) begin
          state_next = READ;
          load_read  = 1'b1;
        end else if (!fifo_empty) begin
          state_next = WRITE;
          load_write = 1'b1;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          fifo_pop   = 1'b1;
          state_next = IDLE;
        end
      end
      READ: begin
        if (bus.mem_ready) begin
          rd_ack_c   = 1'b1;
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.mem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory outputs are loaded at the IDLE decision and held until the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_write) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= ADDR_WIDTH'(head_entry.addr);
        mem_wdata_q <= head_entry.data;
      end else if (load_read) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= bus.rd_addr;
      end else if ((state == WRITE || state == READ) && bus.mem_ready) begin
        mem_req_q <= 1'b0;
      end
      rd_valid_q <= (state == WAIT_DATA) && bus.mem_rvalid;
      if ((state == WAIT_DATA) && bus.mem_rvalid) rd_data_q <= bus.mem_rdata;
      if (bus.dl_wr && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_ack    = rd_ack_c;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = !fifo_empty || (state != IDLE);

`ifdef ARB_STATS_EN
  logic [15:0] wr_count, rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (mem_req_q && bus.mem_ready) begin
      if (mem_we_q && wr_count != 16'hFFFF)  wr_count <= wr_count + 1'b1;
      if (!mem_we_q && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
    end
  end

  assign bus.stat_wr_count = wr_count;
  assign bus.stat_rd_count = rd_count;
`else
  assign bus.stat_wr_count = 16'h0000;
  assign bus.stat_rd_count = 16'h0000;
`endif
endmodule
